// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a small circular FIFO of bytes feeding a
// start/data/stop shifter; one bit period is uart_divider+1 clocks.
module uart_tx_buf #(
    parameter int FIFO_AW = 2
) (
    input  logic               uart_clk,
    input  logic               uart_rst,
    input  logic [15:0]        uart_divider,
    input  logic [7:0]         uart_tx_data,
    input  logic               uart_tx_valid,
    output logic               uart_tx_ready,
    output logic               uart_ser_tx,
    output logic               uart_tx_busy,
    output logic [FIFO_AW:0]   uart_tx_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0] LVL_FULL = DEPTH[FIFO_AW:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q, level_d;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        ser_q, ser_d;

    logic push, pop, fifo_nonempty, bit_end;

    assign uart_tx_ready = (level_q != LVL_FULL);
    assign uart_tx_level = level_q;
    assign uart_ser_tx   = ser_q;
    assign uart_tx_busy  = (state_q != ST_IDLE);

    assign push          = uart_tx_valid && uart_tx_ready;
    assign fifo_nonempty = (level_q != '0);
    assign bit_end       = (cnt_q == div_q);

    // Storage has no reset: pointers and level define what is valid.
    always_ff @(posedge uart_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_tx_data;
        end
    end

    always_ff @(posedge uart_clk or posedge uart_rst) begin
        if (uart_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            ser_q    <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            ser_q   <= ser_d;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        ser_d   = ser_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ser_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = uart_divider;
                    cnt_d   = '0;
                    ser_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    ser_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        ser_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        ser_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame so there is no idle gap.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        div_d   = uart_divider;
                        ser_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ser_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: hand-written frame vectors, multi-cycle corner cases,
// and a random stream decoded off the serial line against a byte queue.
module tb_uart_tx_buf;

    logic        clk;
    logic        rst;
    logic [15:0] div;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ser;
    logic        busy;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b1;

    // Each entry is {divider in force for that frame, byte}.
    logic [23:0] exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [9:0]  frame;      // line bits in send order, bit 0 first
        int          busy_clks;
    } vec_t;

    vec_t vecs[5];

    uart_tx_buf #(.FIFO_AW(2)) dut (
        .uart_clk      (clk),
        .uart_rst      (rst),
        .uart_divider  (div),
        .uart_tx_data  (tx_data),
        .uart_tx_valid (tx_valid),
        .uart_tx_ready (tx_ready),
        .uart_ser_tx   (ser),
        .uart_tx_busy  (busy),
        .uart_tx_level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] d);
        int t = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (tx_ready) begin
            exp_q.push_back({div, d});
            @(negedge clk);
        end else begin
            check("push_timeout", 32'd0, 32'd1);
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy || level != 3'd0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (busy || level != 3'd0) check("idle_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    // Line monitor: checks every sample of a frame and decodes it mid-bit.
    task automatic check_frame();
        logic [23:0] e;
        logic [9:0]  f;
        logic [7:0]  rx;
        logic [7:0]  b;
        int          bl;
        int          bad_i;
        bit          have;
        rx    = '0;
        bad_i = -1;
        have  = (exp_q.size() != 0);
        if (have) e = exp_q.pop_front();
        else e = {div, 8'h00};
        b  = e[7:0];
        bl = int'(e[23:8]) + 1;
        f  = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * bl; i++) begin
            if (i > 0) @(negedge clk);
            if (rst || !mon_en) return;
            if ((ser !== f[i / bl] || busy !== 1'b1) && bad_i < 0) bad_i = i;
            if ((i % bl) == (bl / 2) && (i / bl) >= 1 && (i / bl) <= 8) rx[(i / bl) - 1] = ser;
        end
        if (!have) begin
            check("unexpected_frame", 32'd1, 32'd0);
        end else begin
            check("frame_first_bad_sample", bad_i, -1);
            check("rx_byte", {24'd0, rx}, {24'd0, b});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && ser === 1'b0) check_frame();
        end
    end

    initial begin
        vecs[0] = '{data: 8'hA5, div: 16'd3, frame: 10'b1_1010_0101_0, busy_clks: 40};
        vecs[1] = '{data: 8'h00, div: 16'd0, frame: 10'b1_0000_0000_0, busy_clks: 10};
        vecs[2] = '{data: 8'hFF, div: 16'd1, frame: 10'b1_1111_1111_0, busy_clks: 20};
        vecs[3] = '{data: 8'h3C, div: 16'd2, frame: 10'b1_0011_1100_0, busy_clks: 30};
        vecs[4] = '{data: 8'h81, div: 16'd5, frame: 10'b1_1000_0001_0, busy_clks: 60};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        div      = 16'd3;
        repeat (3) @(negedge clk);
        check("reset_ser", {31'd0, ser}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_level", {29'd0, level}, 32'd0);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single frames from the vector table.
        foreach (vecs[v]) begin
            int bl;
            int i;
            logic [9:0] cap;
            cap = '0;
            wait_idle(1000);
            div = vecs[v].div;
            bl  = int'(vecs[v].div) + 1;
            push_byte(vecs[v].data);
            check("lat_level_after_accept", {29'd0, level}, 32'd1);
            check("lat_line_still_high", {31'd0, ser}, 32'd1);
            @(negedge clk);
            check("lat_start_low", {31'd0, ser}, 32'd0);
            check("lat_level_back_to_0", {29'd0, level}, 32'd0);
            i = 0;
            while (busy && i < 2000) begin
                if ((i % bl) == bl - 1 && (i / bl) < 10) cap[i / bl] = ser;
                i++;
                @(negedge clk);
            end
            check("vec_busy_clks", i, vecs[v].busy_clks);
            check("vec_frame", {22'd0, cap}, {22'd0, vecs[v].frame});
            check("vec_end_level", {29'd0, level}, 32'd0);
            check("vec_end_ready", {31'd0, tx_ready}, 32'd1);
            check("vec_end_ser", {31'd0, ser}, 32'd1);
        end

        // Back-to-back frames at divider 0: busy must stay high for 30 clocks.
        wait_idle(1000);
        div = 16'd0;
        fork
            begin
                push_byte(8'h00);
                push_byte(8'hFF);
                push_byte(8'h55);
            end
            begin
                int t = 0;
                int n = 0;
                while (!busy && t < 100) begin @(negedge clk); t++; end
                while (busy && n < 1000) begin n++; @(negedge clk); end
                check("b2b_busy_clks", n, 30);
            end
        join

        // Valid held high: five accepts before the first stall, data scrambled while stalled.
        wait_idle(1000);
        div = 16'd7;
        begin
            int acc = 0;
            int t = 0;
            bit stalled = 1'b0;
            tx_data  = 8'($urandom);
            tx_valid = 1'b1;
            while (acc < 9 && t < 3000) begin
                if (tx_ready) begin
                    exp_q.push_back({div, tx_data});
                    acc++;
                    @(negedge clk);
                    tx_data = 8'($urandom);
                end else begin
                    if (!stalled) begin
                        stalled = 1'b1;
                        check("accepts_before_stall", acc, 5);
                        check("level_at_stall", {29'd0, level}, 32'd4);
                    end
                    @(negedge clk);
                    tx_data = 8'($urandom);
                end
                t++;
            end
            tx_valid = 1'b0;
            check("bp_accepted", acc, 9);
        end

        // Divider change mid-frame: 4-clock bits then 10-clock bits.
        wait_idle(3000);
        div = 16'd3;
        fork
            begin
                push_byte(8'h5A);
                repeat (14) @(negedge clk);
                div = 16'd9;
                push_byte(8'hC3);
            end
            begin
                int t = 0;
                int n = 0;
                while (!busy && t < 100) begin @(negedge clk); t++; end
                while (busy && n < 1000) begin n++; @(negedge clk); end
                check("divchg_busy_clks", n, 140);
            end
        join

        // Asynchronous reset in the middle of the data bits.
        wait_idle(2000);
        div = 16'd3;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_level", {29'd0, level}, 32'd2);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("rst_ser_async", {31'd0, ser}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        mon_en = 1'b1;
        begin
            int activity = 0;
            repeat (100) begin
                if (ser !== 1'b1 || busy !== 1'b0) activity++;
                @(negedge clk);
            end
            check("no_frame_after_rst", activity, 0);
        end

        // Random stream: batches at a random divider, random gaps between pushes.
        for (int batch = 0; batch < 8; batch++) begin
            wait_idle(5000);
            div = 16'($urandom_range(0, 3));
            for (int k = 0; k < 32; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push_byte(8'($urandom_range(0, 255)));
            end
        end
        wait_idle(5000);
        repeat (2) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
